// File: rtl/seq_detector_param.sv
// Parametrised Mealy sequence detector with runtime-loadable pattern, registered match and saturating hit counter.
// Optional build macro SEQ_DET_MASK_EN adds a per-bit don't-care mask loaded alongside the pattern.
module seq_detector_param #(
  parameter int SYM_W   = 2,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8,
  parameter logic [SYM_W*SEQ_LEN-1:0] RST_PAT = 8'h6D
) (
  input  logic                       CP,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [SYM_W-1:0]           x,
  input  logic                       overlap,
  input  logic                       pat_load,
  input  logic [SYM_W*SEQ_LEN-1:0]   pat_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [SYM_W*SEQ_LEN-1:0]   pat_mask_in,
`endif
  output logic                       Z,
  output logic                       Z_q,
  output logic [$clog2(SEQ_LEN+1)-1:0] y,
  output logic [CNT_W-1:0]           hit_cnt
);

  localparam int PAT_W  = SYM_W * SEQ_LEN;
  localparam int HIST_W = SYM_W * (SEQ_LEN - 1);
  localparam int Y_W    = $clog2(SEQ_LEN + 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SEQ_LEN - 1);

  logic [PAT_W-1:0]  pattern;
  logic [HIST_W-1:0] history;
  logic [PAT_W-1:0]  window;
  logic              window_hit;

  // The window is the oldest stored symbol in the MSBs through the live symbol in the LSBs.
  assign window = {history, x};

`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] mask;
  assign window_hit = ((window ^ pattern) & mask) == '0;
`else
  assign window_hit = (window == pattern);
`endif

  assign Z = en & rst_n & ~pat_load & (y >= Y_MAX) & window_hit;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CP) begin
    if (!rst_n) begin
      pattern <= RST_PAT;
`ifdef SEQ_DET_MASK_EN
      mask    <= '1;
`endif
      history <= '0;
      y       <= '0;
      Z_q     <= 1'b0;
      hit_cnt <= '0;
    end else begin
      Z_q <= Z;
      if (pat_load) begin
        pattern <= pat_in;
`ifdef SEQ_DET_MASK_EN
        mask    <= pat_mask_in;
`endif
        history <= '0;
        y       <= '0;
        hit_cnt <= '0;
      end else if (en) begin
        if (Z) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
          if (overlap) begin
            history <= window[HIST_W-1:0];
          end else begin
            // Non-overlapping: matched symbols must not seed the next match.
            history <= '0;
            y       <= '0;
          end
        end else begin
          history <= window[HIST_W-1:0];
          y       <= (y < Y_MAX) ? y + 1'b1 : Y_MAX;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboarded random + directed bench for seq_detector_param, using a queue-based reference model.
module tb_seq_detector_param;

  localparam int SYM_W   = 2;
  localparam int SEQ_LEN = 4;
  localparam int PAT_W   = SYM_W * SEQ_LEN;
  localparam int Y_W     = $clog2(SEQ_LEN + 1);
  localparam logic [PAT_W-1:0] RST_PAT = 8'h6D;
  localparam int MAX8 = 255;
  localparam int MAX2 = 3;

  logic             CP = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [SYM_W-1:0] x = '0;
  logic             overlap = 1'b1;
  logic             pat_load = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic [PAT_W-1:0] pat_mask_in = '1;
  logic             z_a, zq_a, z_b, zq_b;
  logic [Y_W-1:0]   y_a, y_b;
  logic [7:0]       hit_a;
  logic [1:0]       hit_b;

  seq_detector_param #(.SYM_W(SYM_W), .SEQ_LEN(SEQ_LEN), .CNT_W(8), .RST_PAT(RST_PAT)) dut (
    .CP(CP), .rst_n(rst_n), .en(en), .x(x), .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .Z(z_a), .Z_q(zq_a), .y(y_a), .hit_cnt(hit_a));

  seq_detector_param #(.SYM_W(SYM_W), .SEQ_LEN(SEQ_LEN), .CNT_W(2), .RST_PAT(RST_PAT)) dut_sat (
    .CP(CP), .rst_n(rst_n), .en(en), .x(x), .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .Z(z_b), .Z_q(zq_b), .y(y_b), .hit_cnt(hit_b));

  always #5 CP = ~CP;

  typedef struct {
    logic z;
    logic zq;
    int   y;
    int   hit8;
    int   hit2;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: pattern as a list of symbols, history as a queue of accepted symbols.
  logic [PAT_W-1:0] m_pat;
  logic [PAT_W-1:0] m_mask;
  int   m_hist[$];
  int   m_hit8, m_hit2;
  logic m_z_prev;
  logic m_zq;
  bit   m_valid = 0;

  function automatic int sym(input logic [PAT_W-1:0] p, input int i);
    logic [PAT_W-1:0] s;
    s = p >> ((SEQ_LEN - 1 - i) * SYM_W);
    return int'(s) & ((1 << SYM_W) - 1);
  endfunction

  function automatic logic model_z();
    int w;
    if (!(en && rst_n && !pat_load)) return 1'b0;
    if (m_hist.size() != SEQ_LEN - 1) return 1'b0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      w = (i < SEQ_LEN - 1) ? m_hist[i] : int'(x);
      if (((w ^ sym(m_pat, i)) & sym(m_mask, i)) != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Advance the model across the edge that just consumed the currently driven inputs.
  task automatic model_edge();
    m_zq = m_z_prev;
    if (!rst_n) begin
      m_pat = RST_PAT; m_mask = '1; m_hist.delete(); m_hit8 = 0; m_hit2 = 0; m_zq = 1'b0;
      m_valid = 1;
    end else if (!m_valid) begin
      return;
    end else if (pat_load) begin
`ifdef SEQ_DET_MASK_EN
      m_mask = pat_mask_in;
`endif
      m_pat = pat_in; m_hist.delete(); m_hit8 = 0; m_hit2 = 0;
    end else if (en) begin
      if (m_z_prev) begin
        if (m_hit8 < MAX8) m_hit8++;
        if (m_hit2 < MAX2) m_hit2++;
        if (overlap) begin
          m_hist.push_back(int'(x));
          void'(m_hist.pop_front());
        end else begin
          m_hist.delete();
        end
      end else begin
        m_hist.push_back(int'(x));
        if (m_hist.size() > SEQ_LEN - 1) void'(m_hist.pop_front());
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input int xv, input logic ov,
                      input logic ld, input logic [PAT_W-1:0] pin);
    exp_t ex;
    @(posedge CP);
    #1;
    model_edge();
    rst_n = r; en = e; x = SYM_W'(xv); overlap = ov; pat_load = ld; pat_in = pin;
    m_z_prev = model_z();
    if (m_valid) begin
      ex.z = m_z_prev; ex.zq = m_zq; ex.y = m_hist.size(); ex.hit8 = m_hit8; ex.hit2 = m_hit2;
      exp_q.push_back(ex);
    end
  endtask

  task automatic feed(input logic ov, input int s0, input int s1, input int s2, input int s3);
    step(1, 1, s0, ov, 0, '0);
    step(1, 1, s1, ov, 0, '0);
    step(1, 1, s2, ov, 0, '0);
    step(1, 1, s3, ov, 0, '0);
  endtask

  // Idle one cycle, then look at the settled state at that cycle's falling edge.
  task automatic settle();
    step(1, 0, 0, overlap, 0, '0);
    @(negedge CP);
    #1;
  endtask

  initial begin : monitor
    exp_t ex;
    forever begin
      @(negedge CP);
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        check("Z", int'(z_a), int'(ex.z));
        check("Z_q", int'(zq_a), int'(ex.zq));
        check("y", int'(y_a), ex.y);
        check("hit_cnt", int'(hit_a), ex.hit8);
        check("hit_cnt_w2", int'(hit_b), ex.hit2);
        check("Z_w2", int'(z_b), int'(ex.z));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [PAT_W-1:0] cur_pat;
    int j;
    m_z_prev = 1'b0;

    // Reset, random traffic, then a 2-edge mid-stream reset.
    step(0, 0, 0, 1, 0, '0);
    step(0, 0, 0, 1, 0, '0);
    repeat (10) step(1, 1, $urandom_range(0, 3), 1, 0, '0);
    step(0, 1, 1, 1, 0, '0);
    step(0, 1, 1, 1, 0, '0);
    settle();
    check("reset_y", int'(y_a), 0);
    check("reset_hit", int'(hit_a), 0);
    check("reset_zq", int'(zq_a), 0);
    feed(1, 1, 2, 3, 1);
    settle();
    check("rst_pat_hit", int'(hit_a), 1);

    // Basic detection with a leading junk symbol.
    step(0, 0, 0, 1, 0, '0);
    step(1, 1, 0, 1, 0, '0);
    feed(1, 1, 2, 3, 1);
    settle();
    check("basic_hit", int'(hit_a), 1);
    check("basic_y", int'(y_a), 3);

    // Overlapping vs non-overlapping on 01 repeated.
    step(1, 0, 0, 1, 1, 8'h55);
    repeat (6) step(1, 1, 1, 1, 0, '0);
    settle();
    check("ovl_hit", int'(hit_a), 3);
    step(1, 0, 0, 0, 1, 8'h55);
    repeat (6) step(1, 1, 1, 0, 0, '0);
    settle();
    check("novl_hit", int'(hit_a), 1);
    check("novl_y", int'(y_a), 2);

    // en gating.
    step(1, 0, 0, 1, 1, 8'h6D);
    step(1, 1, 1, 1, 0, '0);
    step(1, 1, 2, 1, 0, '0);
    repeat (3) step(1, 0, 3, 1, 0, '0);
    step(1, 1, 3, 1, 0, '0);
    step(1, 1, 1, 1, 0, '0);
    settle();
    check("en_gate_hit", int'(hit_a), 1);

    // Saturation on both counter widths.
    step(1, 0, 0, 1, 1, 8'h55);
    repeat (9) step(1, 1, 1, 1, 0, '0);
    settle();
    check("sat2_hit", int'(hit_b), 3);
    check("sat8_hit", int'(hit_a), 6);
    repeat (300) step(1, 1, 1, 1, 0, '0);
    settle();
    check("sat8_hold", int'(hit_a), 255);

    // Load collides with the completing symbol.
    step(1, 0, 0, 1, 1, 8'h6D);
    step(1, 1, 1, 1, 0, '0);
    step(1, 1, 2, 1, 0, '0);
    step(1, 1, 3, 1, 0, '0);
    step(1, 1, 1, 1, 1, 8'h6D);
    settle();
    check("collide_y", int'(y_a), 0);
    check("collide_hit", int'(hit_a), 0);
    step(1, 1, 3, 1, 0, '0);
    step(1, 1, 1, 1, 0, '0);
    settle();
    check("collide_nohit", int'(hit_a), 0);
    feed(1, 1, 2, 3, 1);
    settle();
    check("collide_full", int'(hit_a), 1);

    // Randomised traffic biased towards the active pattern so matches are frequent.
    cur_pat = 8'h6D;
    j = 0;
    for (int k = 0; k < 4000; k++) begin
      logic r, e, ov, ld;
      logic [PAT_W-1:0] pin;
      int xv;
      r   = ($urandom_range(0, 199) != 0);
      e   = ($urandom_range(0, 6) != 0);
      ld  = ($urandom_range(0, 59) == 0);
      ov  = (k % 500) < 250;
      case ($urandom_range(0, 3))
        0: pin = 8'h55;
        1: pin = 8'h00;
        2: pin = 8'h6D;
        default: pin = PAT_W'($urandom);
      endcase
      xv = ($urandom_range(0, 3) != 0) ? sym(cur_pat, j % SEQ_LEN) : $urandom_range(0, 3);
      if (e) j++;
      if (!r) cur_pat = RST_PAT;
      else if (ld) begin
        cur_pat = pin;
        j = 0;
      end
      step(r, e, xv, ov, ld, ld ? pin : '0);
    end

    settle();
    repeat (4) @(negedge CP);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
